// File: rtl/reg_file_if.sv
// reg_file_if: read/write port bundle between the write-back/decode logic (master) and the register file (slave).
`timescale 1ns/100ps
interface reg_file_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 4
);
    logic [AW-1:0]    RA1;
    logic [AW-1:0]    RA2;
    logic [AW-1:0]    WA3;
    logic [WIDTH-1:0] WD3;
    logic             WE3;
    logic [WIDTH-1:0] R15;
    logic [WIDTH-1:0] RD1;
    logic [WIDTH-1:0] RD2;
    modport master (output RA1, RA2, WA3, WD3, WE3, R15, input RD1, RD2);
    modport slave  (input RA1, RA2, WA3, WD3, WE3, R15, output RD1, RD2);
endinterface

// File: rtl/reg_file.sv
// reg_file: 16x32 register file, two async read ports, one sync write port, reads of PC_REG return R15.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
`timescale 1ns/100ps
module reg_file #(
    parameter int WIDTH  = 32,
    parameter int NREGS  = 16,
    parameter int PC_REG = 15
) (
    input logic       clk,
    input logic       reset_n,
    reg_file_if.slave bus
);
    localparam int AW = $clog2(NREGS);
    localparam logic [AW-1:0] PC_A = AW'(PC_REG);
`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif
    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic             wr_en;
    assign wr_en = bus.WE3 && (bus.WA3 != PC_A);
    always_comb begin
        regs_d = regs_q;
        if (wr_en) regs_d[bus.WA3] = bus.WD3;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end
    // PC_REG always wins over the bypass path
    always_comb begin
        bus.RD1 = (bus.RA1 == PC_A) ? bus.R15 :
                  (BYPASS && wr_en && bus.RA1 == bus.WA3) ? bus.WD3 : regs_q[bus.RA1];
        bus.RD2 = (bus.RA2 == PC_A) ? bus.R15 :
                  (BYPASS && wr_en && bus.RA2 == bus.WA3) ? bus.WD3 : regs_q[bus.RA2];
    end
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed scoreboard bench for reg_file.
`timescale 1ns/100ps
module tb_reg_file;
    logic clk = 1'b0;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] model [15];
    logic [31:0] exp_q [$];
    string       tag_q [$];

    reg_file_if #(.WIDTH(32), .AW(4)) bus ();
    reg_file dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] exp_of(input logic [3:0] a);
        return (a == 4'd15) ? bus.R15 : model[a];
    endfunction

    task automatic push(input string t, input logic [31:0] v);
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [31:0] obs);
        logic [31:0] e;
        string t;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h expected=none", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", t, obs, e);
            end
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.WA3 = a; bus.WD3 = d; bus.WE3 = 1'b1;
        @(negedge clk);
        bus.WE3 = 1'b0;
        if (a != 4'd15) model[a] = d;
    endtask

    task automatic rd(input logic [3:0] a1, input logic [3:0] a2, input string t);
        bus.RA1 = a1; bus.RA2 = a2;
        #1;
        push($sformatf("%s_rd1[%0d]", t, a1), exp_of(a1));
        check(bus.RD1);
        push($sformatf("%s_rd2[%0d]", t, a2), exp_of(a2));
        check(bus.RD2);
    endtask

    initial begin
        for (int i = 0; i < 15; i++) model[i] = '0;
        reset_n = 1'b0;
        bus.WE3 = 1'b1; bus.WA3 = 4'd3; bus.WD3 = 32'hDEADBEEF;
        bus.R15 = 32'h00000108; bus.RA1 = 4'd3; bus.RA2 = 4'd15;
        repeat (2) @(posedge clk);
        #1;
        rd(4'd3, 4'd15, "in_reset");
        @(negedge clk);
        bus.WE3 = 1'b0; reset_n = 1'b1;
        rd(4'd3, 4'd3, "post_reset");
        @(posedge clk);
        rd(4'd3, 4'd0, "post_reset_edge");

        wr(4'd5, 32'h12345678);
        rd(4'd5, 4'd5, "basic");
        rd(4'd6, 4'd5, "basic_other");

        rd(4'd0, 4'd15, "r15");
        wr(4'd15, 32'hFFFFFFFF);
        rd(4'd15, 4'd15, "r15_drop");
        for (int i = 0; i < 15; i++) rd(4'(i), 4'd15, "r15_drop_all");

        wr(4'd7, 32'h11111111);
        @(negedge clk);
        bus.WA3 = 4'd7; bus.WD3 = 32'h22222222; bus.WE3 = 1'b1;
        bus.RA1 = 4'd7; bus.RA2 = 4'd15;
        #1;
`ifdef REGFILE_BYPASS_EN
        push("rdw_before", 32'h22222222);
`else
        push("rdw_before", 32'h11111111);
`endif
        check(bus.RD1);
        push("rdw_pc_no_bypass", 32'h00000108);
        check(bus.RD2);
        @(posedge clk);
        #1;
        bus.WE3 = 1'b0;
        model[7] = 32'h22222222;
        #1;
        push("rdw_after", 32'h22222222);
        check(bus.RD1);

        for (int i = 0; i < 15; i++) wr(4'(i), 32'(i + 1));
        rd(4'd0, 4'd14, "fill");
        rd(4'd9, 4'd4, "fill");
        @(negedge clk);
        reset_n = 1'b0;
        for (int i = 0; i < 15; i++) model[i] = '0;
        #0.5;
        for (int i = 0; i < 15; i++) begin
            bus.RA1 = 4'(i); bus.RA2 = 4'(14 - i);
            #0.1;
            push($sformatf("async_rst_rd1[%0d]", i), 32'h0);
            check(bus.RD1);
            push($sformatf("async_rst_rd2[%0d]", 14 - i), 32'h0);
            check(bus.RD2);
        end
        #1.0;
        reset_n = 1'b1;

        for (int i = 0; i < 15; i++) wr(4'(i), 32'hA5A50000 + 32'(i));
        for (int i = 0; i < 15; i++) rd(4'(i), 4'(14 - i), "sweep");

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
